// File: rtl/conv1d_engine_pkg.sv
// ============================================================================
// conv1d_engine_pkg : shared state encoding and parameter legality check
// Rev 1.0
// ============================================================================
`default_nettype none

package conv1d_engine_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } conv_state_t;

  // True when the accumulator can never overflow and the filter fits the data.
  function automatic bit params_ok(input int dw, input int data_n, input int filter_n,
                                   input int lg_filter_n, input int acc_w);
    return (acc_w >= 2 * dw + lg_filter_n) && (filter_n >= 2) && (filter_n <= data_n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv1d_engine_mac.sv
// ============================================================================
// conv1d_engine_mac : registered signed multiply feeding a sign-extended accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module conv1d_engine_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             prod_en_i,
  input  logic             acc_en_i,
  input  logic [DW-1:0]    x_i,
  input  logic [DW-1:0]    f_i,
  output logic [ACC_W-1:0] acc_sum_o
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [2*DW-1:0]  prod_q;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign w_prod     = $signed(x_i) * $signed(f_i);
  assign w_prod_ext = {{(ACC_W - 2 * DW){prod_q[2*DW-1]}}, prod_q};
  assign acc_sum_o  = acc_q + w_prod_ext;

  // The product lags its issue by one cycle, so the sum always folds in last cycle's product.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_sum_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (prod_en_i) begin
        prod_q <= w_prod;
      end
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv1d_engine_mem.sv
// ============================================================================
// conv1d_engine_mem : single-write-port register file with combinational read
// Rev 1.0
// ============================================================================
`default_nettype none

module conv1d_engine_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/conv1d_engine.sv
// ============================================================================
// conv1d_engine : self-sequencing 1-D valid convolution with stream handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

module conv1d_engine
  import conv1d_engine_pkg::*;
#(
  parameter int DW          = 8,
  parameter int DATA_N      = 8,
  parameter int FILTER_N    = 4,
  parameter int LG_DATA_N   = 3,
  parameter int LG_FILTER_N = 2,
  parameter int ACC_W       = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    s_data_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic [DW-1:0]    s_data_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic             relu_en,
  output logic [ACC_W-1:0] m_data_y,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             busy
);

  localparam logic [LG_DATA_N:0]     C_X_LAST = (LG_DATA_N + 1)'(DATA_N - 1);
  localparam logic [LG_DATA_N:0]     C_X_FULL = (LG_DATA_N + 1)'(DATA_N);
  localparam logic [LG_FILTER_N:0]   C_F_LAST = (LG_FILTER_N + 1)'(FILTER_N - 1);
  localparam logic [LG_FILTER_N:0]   C_F_FULL = (LG_FILTER_N + 1)'(FILTER_N);
  localparam logic [LG_FILTER_N-1:0] C_K_LAST = (LG_FILTER_N)'(FILTER_N - 1);
  localparam logic [LG_DATA_N-1:0]   C_N_LAST = (LG_DATA_N)'(DATA_N - FILTER_N);

  if (!params_ok(DW, DATA_N, FILTER_N, LG_FILTER_N, ACC_W)) begin : g_bad_params
    $error("conv1d_engine: illegal parameter combination");
  end

  conv_state_t          state_q;
  logic [LG_DATA_N:0]   cnt_x_q;
  logic [LG_FILTER_N:0] cnt_f_q;
  logic [LG_DATA_N-1:0] n_q;
  logic [LG_FILTER_N-1:0] k_q;
  logic                 relu_q;
  logic                 s_ready_x_q;
  logic                 s_ready_f_q;
  logic                 m_valid_y_q;
  logic [ACC_W-1:0]     m_data_y_q;
  logic                 busy_q;

  logic                 w_x_acc;
  logic                 w_f_acc;
  logic [LG_DATA_N-1:0] w_x_raddr;
  logic [DW-1:0]        w_x_rd;
  logic [DW-1:0]        w_f_rd;
  logic                 w_issue;
  logic                 w_acc_clr;
  logic                 w_acc_en;
  logic [ACC_W-1:0]     w_acc_sum;

  assign w_x_acc   = s_valid_x & s_ready_x_q;
  assign w_f_acc   = s_valid_f & s_ready_f_q;
  assign w_x_raddr = n_q + (LG_DATA_N)'(k_q);
  assign w_issue   = (state_q == COMPUTE);
  assign w_acc_clr = w_issue && (k_q == '0);
  assign w_acc_en  = (w_issue && (k_q != '0)) || (state_q == DRAIN);

  conv1d_engine_mem #(.WIDTH(DW), .DEPTH(DATA_N), .AW(LG_DATA_N)) u_x_mem (
    .clk     (clk),
    .we_i    (w_x_acc),
    .waddr_i (cnt_x_q[LG_DATA_N-1:0]),
    .wdata_i (s_data_x),
    .raddr_i (w_x_raddr),
    .rdata_o (w_x_rd)
  );

  conv1d_engine_mem #(.WIDTH(DW), .DEPTH(FILTER_N), .AW(LG_FILTER_N)) u_f_mem (
    .clk     (clk),
    .we_i    (w_f_acc),
    .waddr_i (cnt_f_q[LG_FILTER_N-1:0]),
    .wdata_i (s_data_f),
    .raddr_i (k_q),
    .rdata_o (w_f_rd)
  );

  conv1d_engine_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (w_acc_clr),
    .prod_en_i (w_issue),
    .acc_en_i  (w_acc_en),
    .x_i       (w_x_rd),
    .f_i       (w_f_rd),
    .acc_sum_o (w_acc_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_x_q     <= '0;
      cnt_f_q     <= '0;
      n_q         <= '0;
      k_q         <= '0;
      relu_q      <= 1'b0;
      s_ready_x_q <= 1'b1;
      s_ready_f_q <= 1'b1;
      m_valid_y_q <= 1'b0;
      m_data_y_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (w_x_acc) begin
            cnt_x_q <= cnt_x_q + 1'b1;
            if (cnt_x_q == C_X_LAST) s_ready_x_q <= 1'b0;
          end
          if (w_f_acc) begin
            cnt_f_q <= cnt_f_q + 1'b1;
            if (cnt_f_q == C_F_LAST) s_ready_f_q <= 1'b0;
          end
          if ((cnt_x_q == C_X_FULL) && (cnt_f_q == C_F_FULL)) begin
            state_q <= COMPUTE;
            relu_q  <= relu_en;
            busy_q  <= 1'b1;
            n_q     <= '0;
            k_q     <= '0;
          end
        end
        COMPUTE: begin
          if (k_q == C_K_LAST) begin
            k_q     <= '0;
            state_q <= DRAIN;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DRAIN: begin
          // The sum already includes the final product the MAC absorbs this edge.
          m_data_y_q  <= (relu_q && w_acc_sum[ACC_W-1]) ? '0 : w_acc_sum;
          m_valid_y_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (m_ready_y) begin
            m_valid_y_q <= 1'b0;
            if (n_q == C_N_LAST) begin
              state_q     <= LOAD;
              cnt_x_q     <= '0;
              cnt_f_q     <= '0;
              n_q         <= '0;
              s_ready_x_q <= 1'b1;
              s_ready_f_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              n_q     <= n_q + 1'b1;
              state_q <= COMPUTE;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign s_ready_x = s_ready_x_q;
  assign s_ready_f = s_ready_f_q;
  assign m_data_y  = m_data_y_q;
  assign m_valid_y = m_valid_y_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_conv1d_engine.sv
// ============================================================================
// tb_conv1d_engine : directed and randomized frames against an arithmetic reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv1d_engine;

  localparam int DN   = 8;
  localparam int FN   = 4;
  localparam int NOUT = DN - FN + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data_x = '0;
  logic        s_valid_x = 1'b0;
  logic        s_ready_x;
  logic [7:0]  s_data_f = '0;
  logic        s_valid_f = 1'b0;
  logic        s_ready_f;
  logic        relu_en = 1'b0;
  logic [20:0] m_data_y;
  logic        m_valid_y;
  logic        m_ready_y = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int xv [DN];
  int fv [FN];
  logic [20:0] expq [NOUT];

  always #5 clk = ~clk;

  conv1d_engine dut (
    .clk       (clk),
    .reset     (reset),
    .s_data_x  (s_data_x),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .s_data_f  (s_data_f),
    .s_valid_f (s_valid_f),
    .s_ready_f (s_ready_f),
    .relu_en   (relu_en),
    .m_data_y  (m_data_y),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_ref(input bit relu);
    for (int n = 0; n < NOUT; n++) begin
      int s;
      s = 0;
      for (int k = 0; k < FN; k++) s += xv[n + k] * fv[k];
      if (relu && s < 0) s = 0;
      expq[n] = s[20:0];
    end
  endfunction

  task automatic load_frame(input int gap_pct, input bit extra);
    int ix, jf, cyc;
    bit ax, af;
    ix = 0; jf = 0; cyc = 0;
    while ((ix < DN || jf < FN) && cyc < 500) begin
      s_valid_x = (ix < DN) && ($urandom_range(99) >= gap_pct);
      s_data_x  = (ix < DN) ? xv[ix][7:0] : 8'h00;
      s_valid_f = (jf < FN) && ($urandom_range(99) >= gap_pct);
      s_data_f  = (jf < FN) ? fv[jf][7:0] : 8'h00;
      ax = s_valid_x && s_ready_x;
      af = s_valid_f && s_ready_f;
      @(posedge clk); #1;
      if (ax) ix++;
      if (af) jf++;
      cyc++;
    end
    chk("load_timeout", 32'(cyc < 500), 1);
    if (extra) begin
      for (int i = 0; i < 3; i++) begin
        s_valid_x = 1'b1; s_data_x = 8'h55;
        s_valid_f = 1'b1; s_data_f = 8'hAA;
        chk("extra_ready_x", s_ready_x, 0);
        chk("extra_ready_f", s_ready_f, 0);
        @(posedge clk); #1;
      end
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
  endtask

  task automatic collect(input int nout, input bit rand_ready, input bit check_rate);
    int got, cyc, last;
    bit hold;
    logic [20:0] held;
    got = 0; cyc = 0; last = 0; hold = 1'b0; held = '0;
    while (got < nout && cyc < 3000) begin
      m_ready_y = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      if (hold) begin
        chk("hold_valid", m_valid_y, 1);
        chk("hold_data", m_data_y, held);
      end
      hold = 1'b0;
      if (m_valid_y === 1'b1) begin
        if (m_ready_y) begin
          chk($sformatf("y[%0d]", got), m_data_y, expq[got]);
          if (check_rate && got > 0) chk("rate", cyc - last, FN + 2);
          last = cyc;
          got++;
        end else begin
          hold = 1'b1;
          held = m_data_y;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready_y = 1'b0;
    chk("collect_timeout", got, nout);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy_x"}, s_ready_x, 1);
    chk({tag, "_rdy_f"}, s_ready_f, 1);
    chk({tag, "_valid"}, m_valid_y, 0);
  endtask

  task automatic run_frame(input bit relu, input bit rand_ready, input int gap, input bit extra,
                           input bit rate);
    relu_en = relu;
    build_ref(relu);
    load_frame(gap, extra);
    collect(NOUT, rand_ready, rate);
    check_idle("end");
  endtask

  task automatic rand_data();
    for (int i = 0; i < DN; i++) xv[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < FN; i++) fv[i] = int'($urandom_range(255)) - 128;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_data", m_data_y, 0);
    reset = 1'b0;

    // Ramp data, unit filter, free-flowing sink with throughput check
    for (int i = 0; i < DN; i++) xv[i] = i + 1;
    for (int i = 0; i < FN; i++) fv[i] = 1;
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Same frame under random backpressure
    run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0);

    // Extreme magnitudes
    for (int i = 0; i < DN; i++) xv[i] = -128;
    for (int i = 0; i < FN; i++) fv[i] = -128;
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DN; i++) xv[i] = 127;
    run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0);

    // ReLU on and off with an all-negative result
    for (int i = 0; i < DN; i++) xv[i] = i + 1;
    fv[0] = -1; fv[1] = 0; fv[2] = 0; fv[3] = 0;
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Interleaved gappy loading with extra beats offered after full
    for (int i = 0; i < FN; i++) fv[i] = 1;
    run_frame(1'b0, 1'b1, 50, 1'b1, 1'b0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      rand_data();
      run_frame(1'($urandom_range(1)), 1'b1, 30, 1'($urandom_range(1)), 1'b0);
    end

    // Abort during COMPUTE of n=2, then a fresh frame
    rand_data();
    relu_en = 1'b0;
    build_ref(1'b0);
    load_frame(20, 1'b0);
    collect(2, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("abort");
    rand_data();
    run_frame(1'b1, 1'b1, 20, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
